// File: rtl/ps2_keys_pkg.sv
// ps2_keys_pkg: scancode constants, heading encoding and prefix-FSM state type
// shared by the PS/2 direction decoder and its turn queue.
`default_nettype none

package ps2_keys_pkg;

  // Prefix bytes
  localparam logic [7:0] SC_EXT         = 8'hE0;
  localparam logic [7:0] SC_BRK         = 8'hF0;

  // Extended arrow keys
  localparam logic [7:0] SC_ARROW_UP    = 8'h75;
  localparam logic [7:0] SC_ARROW_RIGHT = 8'h74;
  localparam logic [7:0] SC_ARROW_DOWN  = 8'h72;
  localparam logic [7:0] SC_ARROW_LEFT  = 8'h6B;

  // WASD, space and escape (non-extended)
  localparam logic [7:0] SC_W           = 8'h1D;
  localparam logic [7:0] SC_D           = 8'h23;
  localparam logic [7:0] SC_S           = 8'h1B;
  localparam logic [7:0] SC_A           = 8'h1C;
  localparam logic [7:0] SC_SPACE       = 8'h29;
  localparam logic [7:0] SC_ESC         = 8'h76;

  localparam logic [1:0] DIR_UP         = 2'b00;
  localparam logic [1:0] DIR_RIGHT      = 2'b01;
  localparam logic [1:0] DIR_DOWN       = 2'b10;
  localparam logic [1:0] DIR_LEFT       = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } prefix_state_t;

  // Opposite headings differ only in the upper bit.
  function automatic logic [1:0] opposite_dir(input logic [1:0] h);
    return h ^ 2'b10;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dir_fifo.sv
// dir_fifo: 2-entry, 2-bit-wide turn queue with flush; head is the oldest
// entry, tail the newest. A push onto a full queue only lands with a pop.
`default_nettype none

module dir_fifo (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       push,
  input  logic       pop,
  input  logic [1:0] push_data,
  output logic [1:0] head,
  output logic [1:0] tail,
  output logic [1:0] count
);

  logic [1:0] entry0;
  logic [1:0] entry1;
  logic [1:0] count_r;
  logic       do_pop;

  assign do_pop = pop && (count_r != 2'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r <= 2'd0;
      entry0  <= 2'd0;
      entry1  <= 2'd0;
    end else if (flush) begin
      count_r <= 2'd0;
    end else begin
      case ({push, do_pop})
        2'b10: begin
          if (count_r == 2'd0) begin
            entry0  <= push_data;
            count_r <= 2'd1;
          end else if (count_r == 2'd1) begin
            entry1  <= push_data;
            count_r <= 2'd2;
          end
        end
        2'b01: begin
          entry0  <= entry1;
          count_r <= count_r - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the new entry takes the freed slot.
          if (count_r == 2'd1) begin
            entry0 <= push_data;
          end else begin
            entry0 <= entry1;
            entry1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head  = entry0;
  assign tail  = (count_r == 2'd2) ? entry1 : entry0;
  assign count = count_r;

endmodule

`default_nettype wire

// File: rtl/ps2_dir_decoder.sv
// ps2_dir_decoder: PS/2 scancode prefix decoding, arrow/WASD heading mapping
// with no-reversal turn queue, pause toggle and restart strobe for Snake.
`default_nettype none

module ps2_dir_decoder
  import ps2_keys_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       code_valid,
  input  logic [7:0] code,
  input  logic       game_tick,
  output logic [1:0] dir,
  output logic       dir_changed,
  output logic       paused,
  output logic       restart,
  output logic [1:0] q_count
);

  prefix_state_t state;
  logic          space_held;

  logic       ext_flag;
  logic       brk_flag;
  logic       final_byte;
  logic       is_make;
  logic       turn_valid;
  logic [1:0] turn_dir;
  logic       esc_make;
  logic       space_make;
  logic       space_break;
  logic [1:0] ref_dir;
  logic       turn_ok;
  logic       pop_req;
  logic       push_req;
  logic [1:0] q_head;
  logic [1:0] q_tail;

  always_comb begin
    ext_flag    = (state == ST_EXT) || (state == ST_EXT_BRK);
    brk_flag    = (state == ST_BRK) || (state == ST_EXT_BRK);
    final_byte  = code_valid && (code != SC_EXT) && (code != SC_BRK);
    is_make     = final_byte && !brk_flag;
    turn_valid  = 1'b0;
    turn_dir    = DIR_UP;
    if (is_make) begin
      if (ext_flag) begin
        case (code)
          SC_ARROW_UP:    begin turn_valid = 1'b1; turn_dir = DIR_UP;    end
          SC_ARROW_RIGHT: begin turn_valid = 1'b1; turn_dir = DIR_RIGHT; end
          SC_ARROW_DOWN:  begin turn_valid = 1'b1; turn_dir = DIR_DOWN;  end
          SC_ARROW_LEFT:  begin turn_valid = 1'b1; turn_dir = DIR_LEFT;  end
          default: ;
        endcase
      end else begin
        case (code)
          SC_W: begin turn_valid = 1'b1; turn_dir = DIR_UP;    end
          SC_D: begin turn_valid = 1'b1; turn_dir = DIR_RIGHT; end
          SC_S: begin turn_valid = 1'b1; turn_dir = DIR_DOWN;  end
          SC_A: begin turn_valid = 1'b1; turn_dir = DIR_LEFT;  end
          default: ;
        endcase
      end
    end
    esc_make    = is_make && !ext_flag && (code == SC_ESC);
    space_make  = is_make && !ext_flag && (code == SC_SPACE);
    space_break = final_byte && brk_flag && !ext_flag && (code == SC_SPACE);

    // Reversal is judged against the heading the snake will have once
    // everything already queued has been applied.
    ref_dir  = (q_count != 2'd0) ? q_tail : dir;
    turn_ok  = turn_valid && (turn_dir != ref_dir) && (turn_dir != opposite_dir(ref_dir));
    pop_req  = game_tick && (q_count != 2'd0) && !esc_make;
    push_req = turn_ok && ((q_count != 2'd2) || pop_req) && !esc_make;
  end

  dir_fifo u_dir_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (esc_make),
    .push      (push_req),
    .pop       (pop_req),
    .push_data (turn_dir),
    .head      (q_head),
    .tail      (q_tail),
    .count     (q_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      dir         <= DIR_RIGHT;
      dir_changed <= 1'b0;
      paused      <= 1'b0;
      restart     <= 1'b0;
      space_held  <= 1'b0;
    end else begin
      restart     <= esc_make;
      dir_changed <= pop_req;
      if (esc_make) begin
        dir <= DIR_RIGHT;
      end else if (pop_req) begin
        dir <= q_head;
      end

      if (esc_make) begin
        paused     <= 1'b0;
        space_held <= 1'b0;
      end else if (space_make) begin
        if (!space_held) paused <= !paused;
        space_held <= 1'b1;
      end else if (space_break) begin
        space_held <= 1'b0;
      end

      if (code_valid) begin
        if (code == SC_EXT) begin
          state <= ST_EXT;
        end else if (code == SC_BRK) begin
          case (state)
            ST_IDLE: state <= ST_BRK;
            ST_EXT:  state <= ST_EXT_BRK;
            default: state <= state;
          endcase
        end else begin
          state <= ST_IDLE;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/ps2_dir_decoder.md
# ps2_dir_decoder

Consumes the scancode byte stream from the PS/2 receiver and turns it into Snake game controls. Decodes extended (E0) and break (F0) prefixes, maps arrow keys and WASD to a 2-bit heading, and applies one queued turn per game tick through a 2-entry turn queue with a no-reversal rule. Also produces the pause toggle and restart strobe. Sits between the PS/2 receiver and the game-logic core, all in the system clock domain.

## Interface
- No parameters.
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- code_valid  in  1  one-cycle strobe: code holds a new scancode byte.
- code  in  8  scancode byte from the receiver.
- game_tick  in  1  one-cycle strobe from the game core: apply the next queued turn.
- dir  out  2  current heading: 00 up, 01 right, 10 down, 11 left.
- dir_changed  out  1  one-cycle pulse in the cycle dir takes a new value.
- paused  out  1  pause level.
- restart  out  1  one-cycle restart pulse.
- q_count  out  2  turn-queue occupancy, 0..2.

## Operation
- Prefix FSM states: IDLE, EXT, BRK, EXT_BRK; acts only on cycles with code_valid=1.
  - Byte E0 in any state goes to EXT. Byte F0 goes IDLE→BRK, EXT→EXT_BRK, and BRK/EXT_BRK stay put.
  - Any other byte is a final byte: decode it using the current state's ext/brk flags, then return to IDLE.
- Make codes (brk=0):
  - Extended: 75 up, 74 right, 72 down, 6B left.
  - Non-extended: 1D up, 23 right, 1B down, 1C left; 29 space; 76 escape.
  - All other final bytes are ignored.
- Break codes only affect space: a break of 29 clears space_held. All other break codes are ignored.
- Turn request with heading h:
  - ref = tail queue entry if q_count>0, else dir.
  - Drop the request if h==ref or h is opposite to ref (h == ref XOR 2'b10).
  - Otherwise push h; if the queue is full (2), drop h.
- Space make:
  - If space_held=0, toggle paused and set space_held.
  - Typematic repeats while held are ignored.
- Escape make:
  - Pulse restart.
  - Flush the queue, set dir=01, clear paused and space_held.
  - FSM returns to IDLE.
- game_tick:
  - If q_count>0, pop the head into dir and pulse dir_changed.
  - A tick is honoured even while paused (the game core gates ticks).

## Timing
- Reset values: dir=01, dir_changed=0, paused=0, restart=0, q_count=0, FSM=IDLE, space_held=0, queue contents don't-care.
- code_valid on cycle N: the queue push, paused toggle and restart pulse are visible at N+1.
- game_tick on cycle N: dir and dir_changed are visible at N+1. dir_changed lasts exactly one cycle.
- Push and pop in the same cycle:
  - Both take effect, with ref evaluated on pre-pop contents.
  - Push onto a full queue with a simultaneous pop is accepted; q_count stays 2.
- Escape and game_tick in the same cycle: escape wins. dir=01, q_count=0, dir_changed=0.
- rst_n low mid-sequence (e.g. after E0) discards the pending prefix.
- code_valid is assumed never to be asserted on consecutive cycles less than 1 apart. Every code_valid strobe is consumed.

## Structure
- Package ps2_keys_pkg holds:
  - Scancode constants (E0, F0, arrows, WASD, 29, 76).
  - Heading encoding (DIR_UP..DIR_LEFT) and the FSM state typedef.
- Sub-module dir_fifo: 2-entry, 2-bit-wide queue with push/pop, exposing head, tail, count and flush. The top level contains the prefix FSM, the key mapping, the reversal check and the pause/restart logic.

## Test plan
- Reset, then E0 75, then game_tick → q_count goes 1 then 0; dir=00 and dir_changed pulses once.
- From dir=01: E0 6B (left, reversal) → dropped, q_count=0. Then 1D, 1C, 1B (up, left, down): up and left are queued, and down is dropped because the queue is full. Two ticks → dir=00, then 11.
- 29, 29, 29 (typematic), then F0 29, then 29 → paused goes 1 and stays 1 through the repeats, then 0 after the second make.
- E0 F0 74 (arrow break), then F0 1D (W break) → no push, q_count=0, dir unchanged.
- Queue holding 2 entries with paused=1, then 76 on the same cycle as game_tick → restart pulses, q_count=0, dir=01, paused=0, no dir_changed.
- E0 received, then rst_n low for 1 cycle, then 75 → treated as non-extended 75 and ignored; dir=01.
